// File: rtl/tick_div_pkg.sv
// tick_div_pkg: shared output-mode encoding and the reset divide ratio for the tick divider.
package tick_div_pkg;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  localparam int unsigned TICK_DEFAULT_DIV = 50000;

endpackage

// File: rtl/tick_div_stage.sv
// tick_div_stage: holds the active divisor and a pending divisor, and applies a new one on an apply event.
module tick_div_stage
  import tick_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = TICK_DEFAULT_DIV
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] div_in_i,
  input  logic             div_load_i,
  input  logic             apply_ev_i,
  output logic [WIDTH-1:0] div_o,
  output logic             load_pending_o,
  output logic             apply_o
);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;

  assign apply_o        = apply_ev_i & (div_load_i | pend_valid_q);
  assign div_o          = div_q;
  assign load_pending_o = pend_valid_q;

  // A strobe arriving on the apply edge is newer than anything pending, so it wins.
  always_comb begin
    div_d        = div_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (apply_o) begin
      div_d        = div_load_i ? div_in_i : pend_q;
      pend_valid_d = 1'b0;
    end else if (div_load_i) begin
      pend_d       = div_in_i;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q        <= WIDTH'(DEFAULT_DIV);
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule

// File: rtl/tick_divider.sv
// tick_divider: programmable divider producing a one-cycle tick (PULSE) or a 50% square wave (SQUARE).
module tick_divider
  import tick_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = TICK_DEFAULT_DIV
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] div_in_i,
  input  logic             div_load_i,
  output logic             clk_en_o,
  output logic             clk_sq_o,
  output logic             load_pending_o,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             clk_en_q, clk_en_d;
  logic             clk_sq_q, clk_sq_d;
  logic [WIDTH-1:0] div_w;
  logic [WIDTH-1:0] last_w;
  logic             wrap_w;
  logic             apply_w;
  logic             apply_ev_w;
  mode_e            mode_w;

  assign mode_w = mode_e'(mode_i);

  // Ratios 0 and 1 both collapse to N=1, i.e. the last count value is 0.
  assign last_w     = (div_w <= WIDTH'(1)) ? '0 : div_w - WIDTH'(1);
  assign wrap_w     = enable_i && (count_q == last_w);
  assign apply_ev_w = clear_i | wrap_w | ~enable_i;

  tick_div_stage #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_stage (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .div_in_i       (div_in_i),
    .div_load_i     (div_load_i),
    .apply_ev_i     (apply_ev_w),
    .div_o          (div_w),
    .load_pending_o (load_pending_o),
    .apply_o        (apply_w)
  );

  always_comb begin
    count_d  = count_q;
    clk_en_d = 1'b0;
    clk_sq_d = clk_sq_q;
    if (clear_i || wrap_w || apply_w) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + WIDTH'(1);
    end
    if (!clear_i && wrap_w && mode_w == MODE_PULSE) begin
      clk_en_d = 1'b1;
    end
    if (clear_i || mode_w == MODE_PULSE) begin
      clk_sq_d = 1'b0;
    end else if (wrap_w) begin
      clk_sq_d = ~clk_sq_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      clk_en_q <= 1'b0;
      clk_sq_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      clk_en_q <= clk_en_d;
      clk_sq_q <= clk_sq_d;
    end
  end

  assign clk_en_o = clk_en_q;
  assign clk_sq_o = clk_sq_q;
  assign count_o  = count_q;

endmodule

// File: doc/tick_divider.md
TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 Parameter WIDTH, default 16: counter and divisor width in bits.
REQ-002 Parameter DEFAULT_DIV, default 50000: divide ratio loaded at reset.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low; low forces reset state immediately.
REQ-005 enable  input  1  high = counter advances this cycle; low = hold (pause).
REQ-006 clear  input  1  synchronous restart of the count phase.
REQ-007 mode  input  1  0 = PULSE, 1 = SQUARE; selects which output is driven active.
REQ-008 div_in  input  WIDTH  new divide ratio N.
REQ-009 div_load  input  1  one-cycle strobe capturing div_in.
REQ-010 clk_en  output  1  registered one-cycle tick, once per N enabled cycles (PULSE mode).
REQ-011 clk_sq  output  1  registered square wave, period 2N enabled cycles (SQUARE mode).
REQ-012 load_pending  output  1  high while a captured divisor awaits application.
REQ-013 count  output  WIDTH  current counter value, 0..N-1.

Function
REQ-014 Effective ratio N = active divisor; values 0 and 1 both SHALL be treated as N=1.
REQ-015 With enable=1, count SHALL increment by 1 per cycle and wrap from N-1 to 0; with enable=0, all state SHALL hold.
REQ-016 Wrap = enable=1 and count==N-1; in PULSE mode clk_en SHALL be 1 in the cycle after each wrap, else 0.
REQ-017 With N=1 and enable held high in PULSE mode, clk_en SHALL be 1 every cycle.
REQ-018 In SQUARE mode clk_sq SHALL toggle on each wrap; clk_en SHALL stay 0.
REQ-019 In PULSE mode clk_sq SHALL stay 0; changing mode SHALL zero clk_sq on the next edge without disturbing count.
REQ-020 div_load SHALL copy div_in into a pending register and set load_pending=1; a second div_load before application SHALL overwrite it.
REQ-021 Pending divisor SHALL become active on the next wrap edge, at which count goes to 0 and load_pending clears.
REQ-022 If enable=0 when div_load or pending exists, divisor SHALL apply immediately on the next edge, count reset to 0.
REQ-023 div_load coincident with a wrap SHALL apply div_in at that wrap directly; load_pending SHALL remain 0.
REQ-024 If a new N is at or below current count, the next wrap SHALL still occur only at application; no count beyond old N-1.
REQ-025 clear=1 SHALL on next edge set count=0, clk_en=0, clk_sq=0, and apply any pending/coincident divisor.
REQ-026 Priority per edge: reset > clear > divisor application > count advance.
REQ-027 Counter arithmetic SHALL be modulo-WIDTH unsigned; N = 2^WIDTH-1 maximum usable ratio.

Reset
REQ-028 On reset low: count=0, active divisor=DEFAULT_DIV, pending cleared, load_pending=0, clk_en=0, clk_sq=0.
REQ-029 After reset release, first clk_en (PULSE, enable high) SHALL appear exactly N cycles after the first enabled edge.
REQ-030 Reset asserted mid-count or with a pending load SHALL discard pending divisor and revert to DEFAULT_DIV.

Structure
REQ-031 Package tick_div_pkg SHALL hold the mode encoding (MODE_PULSE=0, MODE_SQUARE=1) and the DEFAULT_DIV default constant.
REQ-032 Divisor staging (pending register, load_pending, apply logic) SHALL be sub-module tick_div_stage; counter and outputs in top.
REQ-033 Target size 120-400 lines RTL; no latches, no combinational path input to output.

Verification
REQ-034 Reset, DEFAULT_DIV, PULSE, enable high 150000 cycles -> exactly 3 clk_en pulses, spacing 50000 cycles.
REQ-035 div_load N=4 while enabled at count 1 (old N=10) -> load_pending high until count 9 wrap, then clk_en every 4 cycles.
REQ-036 N=3 SQUARE, enable high -> clk_sq 3 cycles high, 3 low, repeating; clk_en never asserts.
REQ-037 N=5, toggle enable low for 7 cycles at count 2 -> count holds 2, tick timing shifts by exactly 7 cycles.
REQ-038 div_load N=6 in wrap cycle plus clear asserted at count 3 later -> count 0 next edge, load_pending 0, ticks every 6.
REQ-039 Reset pulsed low asynchronously mid-cycle with pending load -> all outputs 0 immediately, divisor returns to 50000.
